mux2_arbiter: RTL
=================

Name: mux2_arbiter

Overview:
- Upstream control stage for the 2:1 mux (`mux2x1`); drives its `sel` input.
- Arbitrates two requesters for one shared mux output path.
- Round-robin priority; a grant is held until the owner drops its request.
- Registered outputs, so the mux select is glitch-free and changes only on clock edges.

Parameters:
HOLD_MAX, 8, max consecutive cycles one owner may hold the grant while the other requests (used only with ARB_TIMEOUT_EN); legal range 2..255
CW, 8, width of hold counter; must satisfy 2^CW > HOLD_MAX

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  2  request per requester; req[n] held high for the whole transaction
gnt  output 2  registered one-hot grant; 00 when idle
sel  output 1  registered mux select, connected directly to mux2x1 sel; 1 = requester 1 owns the path
valid  output 1  registered; 1 when any grant is active (gnt != 00)

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset, applied at the next rising edge with rst=1:
  - state=IDLE, gnt=00, sel=0, valid=0.
  - Priority pointer prio=0 (requester 0 preferred first).
  - Hold counter=0.
- Latency: req sampled at edge k; gnt/sel/valid update at edge k. Visible one cycle after req is first presented.
- State machine: IDLE, OWN0, OWN1. Outputs: gnt = {state==OWN1, state==OWN0}, valid = |gnt.
- IDLE:
  - req=00: stay.
  - req=01 -> OWN0; req=10 -> OWN1.
  - req=11 -> OWN[prio].
- On every entry into OWNn: prio <= ~n; counter <= 0.
- OWNn while req[n]=1: stay; counter increments, saturating at all-ones.
- OWNn when req[n]=0:
  - req[~n]=1: go directly to OWN[~n] (handover in one edge, no idle bubble).
  - Otherwise go to IDLE.
- Simultaneous req[n] falling and req[~n] rising in the same cycle: direct handover, as above.
- sel:
  - Loads 0 on entry to OWN0, 1 on entry to OWN1.
  - Retains its last value in IDLE, so the mux output is stable; only reset forces it to 0.
- A requester re-raising req immediately after release loses to the other requester if that one is pending (prio already flipped).
- Reset mid-grant: drop to IDLE at that edge regardless of req; the first grant after reset follows prio=0.
- gnt is never 11. gnt, sel and valid are purely registered (no combinational path from req).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In OWNn, if counter == HOLD_MAX-1 and req[~n]=1, force handover to OWN[~n] at the next edge even though req[n]=1.
  - The preempted requester may re-win later by round-robin.
  - If req[~n]=0, the owner keeps the grant and the counter saturates.
- Undefined:
  - Counter logic is absent; an owner holds the grant indefinitely while req[n]=1.
- Port list is identical in both builds.

Decomposition:
- Shared header mux_arb_defs.vh holds:
  - State encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Default HOLD_MAX constant.
- One natural sub-module: arb_hold_cnt (saturating CW-bit counter with clear and enable), instantiated only under ARB_TIMEOUT_EN.
- Top integrates with mux2x1 by wiring sel -> mux sel; the bench instantiates both.

Test Plan:
- Reset: rst=1 for 2 cycles with req=11 -> gnt=00, sel=0, valid=0; after release with req=11 -> gnt=01, sel=0, then priority pointer=1.
- Single requester: req=10 held 4 cycles -> gnt=10, sel=1, valid=1 one edge later; req=00 -> gnt=00, valid=0, sel stays 1.
- Round-robin with back-to-back handover: req=11 constant, owner drops for 1 cycle every 3 cycles -> grants alternate 01,10,01, never 11, no idle cycle between owners.
- Simultaneous edge: in OWN0, req goes 01->10 in one cycle -> next edge gnt=10, sel=1, valid stays 1.
- Mid-operation reset: in OWN1, assert rst for 1 cycle with req=11 -> gnt=00, sel=0; next edge gnt=01.
- ARB_TIMEOUT_EN, HOLD_MAX=4: req=11 held -> grant switches every 4 cycles. With req=01 only, grant stays 01 for 20 cycles and the counter saturates without wrap.

Source files
------------

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int HOLD_MAX_DEF = 8;

  function automatic state_t own_st(input logic n);
    return n ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter: clear wins over enable, sticks at all-ones.
module arb_hold_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mux2x1.sv
// Plain 2:1 data mux steered by the arbiter's registered select.
module mux2x1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin 2-requester arbiter with registered gnt/sel/valid driving mux2x1.
// Optional owner preemption after HOLD_MAX cycles when built with ARB_TIMEOUT_EN.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       valid
);

  localparam logic PARAM_OK = (HOLD_MAX >= 2) && (HOLD_MAX <= 255) && ((64'd1 << CW) > 64'(HOLD_MAX));

  state_t state, nxt;
  logic   prio;
  logic   cur;
  logic   timeout;

  assign cur = (state == ST_OWN1);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] cnt;
  logic          cnt_clr;

  // Counter restarts on every entry into an owner state, including handovers.
  assign cnt_clr = (nxt != state) && (nxt != ST_IDLE);

  arb_hold_cnt #(.CW(CW)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (state != ST_IDLE),
    .cnt (cnt)
  );

  assign timeout = (cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (req == 2'b11) nxt = own_st(prio);
        else if (req[0])  nxt = ST_OWN0;
        else if (req[1])  nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (req[cur] && !(timeout && req[!cur])) nxt = state;
        else if (req[!cur])                      nxt = own_st(!cur);
        else                                     nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (PARAM_OK);
      state <= ST_IDLE;
      gnt   <= 2'b00;
      sel   <= 1'b0;
      valid <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= nxt;
      gnt   <= {nxt == ST_OWN1, nxt == ST_OWN0};
      valid <= (nxt != ST_IDLE);
      // sel and prio only move on entry to an owner; IDLE keeps the last path.
      if (nxt != state && nxt != ST_IDLE) begin
        prio <= (nxt == ST_OWN0);
        sel  <= (nxt == ST_OWN1);
      end
    end
  end

endmodule
